sprite_fetch: RTL and testbench

- Pixel-pipeline stage directly upstream of the sprite vram and downstream of the VGA timing generator.
- Each cycle it tests whether the current (hcount, vcount) lies inside a sprite box latched at frame start, and computes the vram address (including animation frame offset) and enable.
- It consumes the vram's 1-cycle registered read data, applies colour-key transparency, and emits pixel and sync signals aligned to the fetched data.

---
 rtl/sprite_fetch.sv | 168 ++++++++++++++++
 tb/tb_sprite_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch.sv
// Sprite fetch stage: box hit test against a frame-latched position, vram address
// generation with animation frames, and colour-keyed pixel output aligned with syncs.
module sprite_fetch #(
    parameter int                SPR_W    = 32,
    parameter int                SPR_H    = 32,
    parameter int                FRAMES   = 4,
    parameter int                ANIM_DIV = 8,
    parameter int                WIDTH    = 12,
    parameter logic [WIDTH-1:0]  KEY      = 12'hF0F,
    parameter int                CW       = 10,
    localparam int               DEPTH    = SPR_W * SPR_H * FRAMES,
    localparam int               AWIDTH   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              anim_en,
    input  logic [CW-1:0]     x_pos,
    input  logic [CW-1:0]     y_pos,
    input  logic [CW-1:0]     hcount,
    input  logic [CW-1:0]     vcount,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              rom_en,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_data,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              pix_valid,
    output logic [WIDTH-1:0]  pix_rgb
);

    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(ANIM_DIV - 1);

    logic [CW-1:0]     r_xl;
    logic [CW-1:0]     r_yl;
    logic [FW-1:0]     r_frame;
    logic [FW-1:0]     w_frame_nxt;
    logic [DW-1:0]     r_div;
    logic [DW-1:0]     w_div_nxt;

    logic [CW:0]       w_h;
    logic [CW:0]       w_v;
    logic [CW:0]       w_x0;
    logic [CW:0]       w_y0;
    logic [CW:0]       w_x1;
    logic [CW:0]       w_y1;
    logic              w_hit;
    logic [CW-1:0]     w_dh;
    logic [CW-1:0]     w_dv;
    logic [AWIDTH-1:0] w_addr;

    logic              r_rom_en;
    logic [AWIDTH-1:0] r_rom_addr;
    logic              r_hit_d1;
    logic [2:0]        r_sync_d0;
    logic [2:0]        r_sync_d1;
    logic [2:0]        r_sync_out;
    logic              r_pix_valid;
    logic [WIDTH-1:0]  r_pix_rgb;
    logic              w_opaque;
    logic [WIDTH-1:0]  w_rgb_nxt;

    // One extra bit keeps a box hanging off the right/bottom edge from wrapping to 0.
    assign w_h  = {1'b0, hcount};
    assign w_v  = {1'b0, vcount};
    assign w_x0 = {1'b0, r_xl};
    assign w_y0 = {1'b0, r_yl};
    assign w_x1 = w_x0 + (CW+1)'(SPR_W);
    assign w_y1 = w_y0 + (CW+1)'(SPR_H);

    assign w_hit = de_in && (w_h >= w_x0) && (w_h < w_x1) && (w_v >= w_y0) && (w_v < w_y1);

    assign w_dh   = hcount - r_xl;
    assign w_dv   = vcount - r_yl;
    assign w_addr = AWIDTH'(r_frame) * AWIDTH'(SPR_W * SPR_H)
                  + AWIDTH'(w_dv) * AWIDTH'(SPR_W)
                  + AWIDTH'(w_dh);

    // Animation divider and frame counter next state, stepped only on enabled frame starts.
    always_comb begin
        w_frame_nxt = r_frame;
        w_div_nxt   = r_div;
        if (frame_start && anim_en) begin
            if (r_div == DIV_LAST) begin
                w_div_nxt = '0;
                if (r_frame == FRAME_LAST) begin
                    w_frame_nxt = '0;
                end else begin
                    w_frame_nxt = r_frame + 1'b1;
                end
            end else begin
                w_div_nxt   = r_div + 1'b1;
                w_frame_nxt = r_frame;
            end
        end else begin
            w_frame_nxt = r_frame;
            w_div_nxt   = r_div;
        end
    end

    // Output-stage pixel decode from the vram word fetched for the pixel two edges back.
    always_comb begin
        w_opaque  = r_hit_d1 && (rom_data != KEY);
        w_rgb_nxt = '0;
        if (w_opaque) begin
            w_rgb_nxt = rom_data;
        end else begin
            w_rgb_nxt = '0;
        end
    end

    // Sprite position latch and animation state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xl    <= '0;
            r_yl    <= '0;
            r_frame <= '0;
            r_div   <= '0;
        end else begin
            if (frame_start) begin
                r_xl <= x_pos;
                r_yl <= y_pos;
            end
            r_frame <= w_frame_nxt;
            r_div   <= w_div_nxt;
        end
    end

    // Fetch request, hit/sync delay pipe and registered pixel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_hit_d1    <= 1'b0;
            r_sync_d0   <= 3'b000;
            r_sync_d1   <= 3'b000;
            r_sync_out  <= 3'b000;
            r_pix_valid <= 1'b0;
            r_pix_rgb   <= '0;
        end else begin
            r_rom_en <= w_hit;
            if (w_hit) begin
                r_rom_addr <= w_addr;
            end
            r_hit_d1    <= r_rom_en;
            r_sync_d0   <= {de_in, hsync_in, vsync_in};
            r_sync_d1   <= r_sync_d0;
            r_sync_out  <= r_sync_d1;
            r_pix_valid <= w_opaque;
            r_pix_rgb   <= w_rgb_nxt;
        end
    end

    assign rom_en    = r_rom_en;
    assign rom_addr  = r_rom_addr;
    assign de_out    = r_sync_out[2];
    assign hsync_out = r_sync_out[1];
    assign vsync_out = r_sync_out[0];
    assign pix_valid = r_pix_valid;
    assign pix_rgb   = r_pix_rgb;

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the sprite fetch rules.
module tb_sprite_fetch;

    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        anim_en = 1'b0;
    logic [9:0]  x_pos = 10'd0;
    logic [9:0]  y_pos = 10'd0;
    logic [9:0]  hcount = 10'd0;
    logic [9:0]  vcount = 10'd0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        pix_valid;
    logic [11:0] pix_rgb;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [0:4095];

    sprite_fetch dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .anim_en(anim_en),
        .x_pos(x_pos), .y_pos(y_pos), .hcount(hcount), .vcount(vcount),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb)
    );

    always #5 clk = ~clk;

    // vram: one-cycle registered read
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Behavioural model: sprite box, animation counters, and history of the last two samples
    int m_xl, m_yl, m_frame, m_div;
    int p_hit [2];
    int p_addr[2];
    int p_de  [2];
    int p_hs  [2];
    int p_vs  [2];
    int e_en, e_addr, e_de, e_hs, e_vs, e_valid, e_rgb;

    task automatic model_step();
        int h, v, hit, a;
        if (rst) begin
            m_xl = 0; m_yl = 0; m_frame = 0; m_div = 0;
            for (int i = 0; i < 2; i++) begin
                p_hit[i] = 0; p_addr[i] = 0; p_de[i] = 0; p_hs[i] = 0; p_vs[i] = 0;
            end
            e_en = 0; e_addr = 0; e_de = 0; e_hs = 0; e_vs = 0; e_valid = 0; e_rgb = 0;
        end else begin
            h = int'(hcount);
            v = int'(vcount);
            hit = (de_in && h >= m_xl && h < m_xl + 32 && v >= m_yl && v < m_yl + 32) ? 1 : 0;
            a = (m_frame * 1024 + (v - m_yl) * 32 + (h - m_xl)) & 4095;
            e_de = p_de[1]; e_hs = p_hs[1]; e_vs = p_vs[1];
            e_valid = (p_hit[1] != 0 && mem[p_addr[1]] != KEY) ? 1 : 0;
            e_rgb = e_valid ? int'(mem[p_addr[1]]) : 0;
            p_hit[1] = p_hit[0]; p_addr[1] = p_addr[0];
            p_de[1] = p_de[0]; p_hs[1] = p_hs[0]; p_vs[1] = p_vs[0];
            p_hit[0] = hit; p_addr[0] = a;
            p_de[0] = int'(de_in); p_hs[0] = int'(hsync_in); p_vs[0] = int'(vsync_in);
            e_en = hit;
            if (hit != 0) e_addr = a;
            if (frame_start) begin
                m_xl = int'(x_pos);
                m_yl = int'(y_pos);
                if (anim_en) begin
                    m_div = m_div + 1;
                    if (m_div == 8) begin
                        m_div = 0;
                        m_frame = (m_frame + 1) % 4;
                    end
                end
            end
        end
    endtask

    // Per-cycle compare of all outputs against the model
    always begin
        @(posedge clk);
        model_step();
        #1;
        if (!rst) begin
            chk("rom_en",    int'(rom_en),    e_en);
            chk("rom_addr",  int'(rom_addr),  e_addr);
            chk("de_out",    int'(de_out),    e_de);
            chk("hsync_out", int'(hsync_out), e_hs);
            chk("vsync_out", int'(vsync_out), e_vs);
            chk("pix_valid", int'(pix_valid), e_valid);
            chk("pix_rgb",   int'(pix_rgb),   e_rgb);
        end
    end

    task automatic drive(input int de, input int h, input int v, input int fs);
        @(negedge clk);
        de_in       = (de != 0);
        hcount      = 10'(h);
        vcount      = 10'(v);
        frame_start = (fs != 0);
        hsync_in    = 1'($urandom);
        vsync_in    = 1'($urandom);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"},    int'(rom_en),    0);
        chk({tag, "_addr"},  int'(rom_addr),  0);
        chk({tag, "_de"},    int'(de_out),    0);
        chk({tag, "_hs"},    int'(hsync_out), 0);
        chk({tag, "_vs"},    int'(vsync_out), 0);
        chk({tag, "_valid"}, int'(pix_valid), 0);
        chk({tag, "_rgb"},   int'(pix_rgb),   0);
    endtask

    initial begin
        int bx, by, found;
        for (int i = 0; i < 4096; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? KEY : 12'($urandom);
        for (int i = 0; i < 5; i++) mem[i] = 12'h0A3;
        mem[5]    = KEY;
        mem[6]    = 12'h0A3;
        mem[99]   = 12'h123;
        mem[1034] = 12'h5C1;

        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Row sweep across box at (100,50)
        x_pos = 10'd100; y_pos = 10'd50;
        drive(0, 0, 0, 1);
        for (int h = 98; h <= 133; h++) begin
            drive(1, h, 50, 0);
            settle();
            if (h == 99)  chk("sweep_en99", int'(rom_en), 0);
            if (h == 100) begin chk("sweep_en100", int'(rom_en), 1); chk("sweep_addr100", int'(rom_addr), 0); end
            if (h == 131) chk("sweep_addr131", int'(rom_addr), 31);
            if (h == 132) chk("sweep_en132", int'(rom_en), 0);
            if (h == 102) chk("sweep_valid100", int'(pix_valid), 1);
            if (h == 106) chk("key_left_rgb", int'(pix_rgb), 12'h0A3);
            if (h == 107) begin chk("key_valid", int'(pix_valid), 0); chk("key_rgb", int'(pix_rgb), 0); end
            if (h == 108) chk("key_right_rgb", int'(pix_rgb), 12'h0A3);
        end

        // Right-edge clip: no wrap to column 0
        x_pos = 10'd1020; y_pos = 10'd0;
        drive(0, 0, 0, 1);
        for (int h = 0; h < 1024; h++) begin
            drive(1, h, 5, 0);
            settle();
            if (h == 0)    chk("clip_en0", int'(rom_en), 0);
            if (h == 27)   chk("clip_en27", int'(rom_en), 0);
            if (h == 1019) chk("clip_en1019", int'(rom_en), 0);
            if (h == 1020) begin chk("clip_en1020", int'(rom_en), 1); chk("clip_addr1020", int'(rom_addr), 160); end
            if (h == 1023) chk("clip_addr1023", int'(rom_addr), 163);
        end

        // Animation stepping
        x_pos = 10'd0; y_pos = 10'd0;
        anim_en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            drive(0, 0, 0, 1);
            drive(1, 0, 0, 0);
            settle();
            if (i == 7)  chk("anim_p7",  int'(rom_addr), 0);
            if (i == 8)  chk("anim_p8",  int'(rom_addr), 1024);
            if (i == 16) chk("anim_p16", int'(rom_addr), 2048);
            if (i == 24) chk("anim_p24", int'(rom_addr), 3072);
            if (i == 32) chk("anim_p32", int'(rom_addr), 0);
            if (i == 40) chk("anim_p40", int'(rom_addr), 1024);
        end
        anim_en = 1'b0;
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        settle();
        chk("anim_hold", int'(rom_addr), 1024);

        // Position change without frame_start, then frame_start during a hit
        x_pos = 10'd200;
        drive(1, 3, 0, 0);
        settle();
        chk("nolatch_addr", int'(rom_addr), 1027);
        drive(1, 10, 0, 1);
        settle();
        chk("fs_hit_en", int'(rom_en), 1);
        chk("fs_hit_addr", int'(rom_addr), 1034);
        drive(1, 12, 0, 0);
        settle();
        chk("newbox_miss", int'(rom_en), 0);
        drive(1, 205, 0, 0);
        settle();
        chk("newbox_addr", int'(rom_addr), 1029);
        chk("inflight_rgb", int'(pix_rgb), 12'h5C1);

        // Asynchronous reset mid-line while a pixel is valid
        x_pos = 10'd100; y_pos = 10'd50;
        drive(0, 0, 0, 1);
        found = 0;
        for (int h = 100; h < 130 && found == 0; h++) begin
            drive(1, h, 50, 0);
            settle();
            if (pix_valid) found = 1;
        end
        chk("rst_setup_valid", found, 1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 40, 40, 0);
        settle();
        chk("refill_en0", int'(rom_en), 0);
        drive(1, 3, 3, 0);
        settle();
        chk("refill_en", int'(rom_en), 1);
        chk("refill_addr", int'(rom_addr), 99);
        drive(0, 0, 0, 0);
        settle();
        chk("refill_early", int'(pix_valid), 0);
        drive(0, 0, 0, 0);
        settle();
        chk("refill_valid", int'(pix_valid), 1);
        chk("refill_rgb", int'(pix_rgb), 12'h123);

        // Randomized traffic
        bx = 0; by = 0;
        for (int c = 0; c < 3000; c++) begin
            int fs, h, v;
            fs = ($urandom_range(0, 63) == 0) ? 1 : 0;
            anim_en = 1'($urandom);
            if (fs != 0) begin
                bx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
                by = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
                x_pos = 10'(bx);
                y_pos = 10'(by);
            end
            h = ($urandom_range(0, 1) != 0) ? ((bx + int'($urandom_range(0, 40)) - 4) & 1023) : int'($urandom_range(0, 1023));
            v = ($urandom_range(0, 1) != 0) ? ((by + int'($urandom_range(0, 40)) - 4) & 1023) : int'($urandom_range(0, 1023));
            drive(($urandom_range(0, 7) != 0) ? 1 : 0, h, v, fs);
        end
        drive(0, 0, 0, 0);
        settle();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
